// File: rtl/skid_pkg.sv
// ---------------------------------------------------------------------------
// skid_pkg
// Shared constants for the skid_fifo elastic buffer.
// - SKID_DEPTH_DEFAULT / SKID_WIDTH_DEFAULT : default geometry
// - LEVEL_W(depth) : bits needed to hold an occupancy count of 0..depth
// ---------------------------------------------------------------------------
package skid_pkg;

  localparam int SKID_DEPTH_DEFAULT = 4;
  localparam int SKID_WIDTH_DEFAULT = 16;

  // Occupancy runs 0..depth inclusive, so one more code than the pointer width.
  function automatic int LEVEL_W(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/skid_fifo_mem.sv
// ---------------------------------------------------------------------------
// skid_fifo_mem
// DEPTH x WIDTH register array with one synchronous write port and one
// asynchronous read port. The read address comes from a register in the
// parent, so the read data is a mux of flops and carries no input path.
// Ports:
//   i_clock    in   1      clock, rising edge
//   wr_en_i    in   1      write strobe
//   wr_addr_i  in   AW     write address
//   wr_data_i  in   WIDTH  write data
//   rd_addr_i  in   AW     read address (registered by the parent)
//   rd_data_o  out  WIDTH  word at rd_addr_i
// ---------------------------------------------------------------------------
module skid_fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clock,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage write; contents need no reset because the level counter gates reads.
  always_ff @(posedge i_clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/skid_fifo.sv
// ---------------------------------------------------------------------------
// skid_fifo
// Parametrised ready/valid elastic buffer with occupancy level, almost-full
// flag and synchronous flush. All handshake outputs are registered and are
// computed from the next-state level, so there is no combinational path
// from i_out_ready to o_in_ready. Head data appears one edge after a push
// into an empty buffer (no fall-through).
// Ports:
//   i_clock        in   1         clock, rising edge
//   i_reset        in   1         synchronous active-high reset
//   i_flush        in   1         synchronous discard of all stored words
//   i_in_data      in   WIDTH     upstream data
//   i_in_valid     in   1         upstream valid
//   o_in_ready     out  1         upstream ready (registered)
//   o_out_data     out  WIDTH     head of queue
//   o_out_valid    out  1         downstream valid (registered)
//   i_out_ready    in   1         downstream ready
//   o_level        out  LEVEL_W   words stored (registered)
//   o_almost_full  out  1         level >= AFULL_THRESH (registered)
// ---------------------------------------------------------------------------
module skid_fifo
  import skid_pkg::*;
#(
  parameter int WIDTH        = SKID_WIDTH_DEFAULT,
  parameter int DEPTH        = SKID_DEPTH_DEFAULT,
  parameter int AFULL_THRESH = 3
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_flush,
  input  logic [WIDTH-1:0]          i_in_data,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  output logic [WIDTH-1:0]          o_out_data,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [LEVEL_W(DEPTH)-1:0] o_level,
  output logic                      o_almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = LEVEL_W(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_L = LW'(AFULL_THRESH);

  // Elaboration-time parameter checks.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("skid_fifo: DEPTH must be a power of 2 and >= 2");
  end
  if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_afull
    $error("skid_fifo: AFULL_THRESH must be within 1..DEPTH");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          afull_q, afull_d;
  logic          push_s, pop_s, wr_en_s;

  // Handshakes are qualified by the registered flags, so full/empty are
  // decided by the level counter only; pointers just wrap naturally.
  assign push_s  = i_in_valid & in_ready_q;
  assign pop_s   = out_valid_q & i_out_ready;
  assign wr_en_s = push_s & ~i_flush & ~i_reset;

  // Next-state pointers, level and flags; flush beats push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
    in_ready_d  = (level_d < DEPTH_L);
    out_valid_d = (level_d != '0);
    afull_d     = (level_d >= AFULL_L);
  end

  // State registers with synchronous reset that dominates everything else.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      afull_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      afull_q     <= afull_d;
    end
  end

  skid_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clock   (i_clock),
    .wr_en_i   (wr_en_s),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (i_in_data),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (o_out_data)
  );

  assign o_in_ready    = in_ready_q;
  assign o_out_valid   = out_valid_q;
  assign o_level       = level_q;
  assign o_almost_full = afull_q;

endmodule

// File: tb/tb_skid_fifo.sv
// ---------------------------------------------------------------------------
// tb_skid_fifo
// Directed bench for skid_fifo (WIDTH=16, DEPTH=4, AFULL_THRESH=3).
// Data words are a counter of accepted words; every pop is compared with
// the next expected counter value.
// ---------------------------------------------------------------------------
module tb_skid_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int AFT   = 3;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, out_ready;
  logic             in_ready, out_valid, afull;
  logic [WIDTH-1:0] in_data, out_data;
  logic [LW-1:0]    level;

  int n_total = 0;
  int n_bad   = 0;
  int next_in, exp_out, push_cnt, pop_cnt;

  always #5 clk = ~clk;

  skid_fifo #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFT)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_flush       (flush),
    .i_in_data     (in_data),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .o_out_data    (out_data),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_level       (level),
    .o_almost_full (afull)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock: note handshakes before the edge, update the scoreboard after it.
  task automatic tick();
    logic             pu, po;
    logic [WIDTH-1:0] pd;
    pu = in_valid && in_ready && !flush && !rst;
    po = out_valid && out_ready && !flush && !rst;
    pd = out_data;
    @(posedge clk);
    #1;
    if (pu) begin
      push_cnt++;
      next_in++;
    end
    in_data = next_in[WIDTH-1:0];
    if (po) begin
      check_eq("pop_data", {16'd0, pd}, exp_out);
      exp_out++;
      pop_cnt++;
    end
  endtask

  task automatic restart_counts();
    next_in  = 0;
    exp_out  = 0;
    push_cnt = 0;
    pop_cnt  = 0;
    in_data  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    restart_counts();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (out_valid && n < 50) begin
      tick();
      n++;
    end
    check_eq({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    restart_counts();
    do_reset();

    // Reset state and idle
    check_eq("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_level",     {29'd0, level},     32'd0);
    check_eq("rst_afull",     {31'd0, afull},     32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    check_eq("idle_pops",      pop_cnt,            32'd0);
    check_eq("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("idle_level",     {29'd0, level},     32'd0);
    check_eq("idle_in_ready",  {31'd0, in_ready},  32'd1);

    // Fill with downstream stalled, then drain in order
    do_reset();
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_eq("fill_level",    {29'd0, level},    i);
      check_eq("fill_afull",    {31'd0, afull},    (i >= 3) ? 32'd1 : 32'd0);
      check_eq("fill_in_ready", {31'd0, in_ready}, (i < 4) ? 32'd1 : 32'd0);
    end
    check_eq("fill_head", {16'd0, out_data}, 32'd0);
    tick(); tick();
    check_eq("fill_pushes",   push_cnt,       32'd4);
    check_eq("fill_level_hd", {29'd0, level}, 32'd4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_eq("fill_pops",      pop_cnt,            32'd4);
    check_eq("fill_end_level", {29'd0, level},     32'd0);
    check_eq("fill_end_valid", {31'd0, out_valid}, 32'd0);

    // Full, simultaneous push and pop for 20 cycles
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_eq("full_start_level", {29'd0, level}, 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("full_level_3or4", {31'd0, (level == 3'd3) || (level == 3'd4)}, 32'd1);
      check_eq("full_nogap",      {31'd0, out_valid}, 32'd1);
    end
    check_eq("full_pops20",  pop_cnt,  32'd20);
    check_eq("full_pushes",  push_cnt, 32'd23);
    drain("full");
    check_eq("full_in_eq_out", pop_cnt, push_cnt);

    // Bursty upstream and downstream
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ((c % 15) < 5);
      out_ready = ((c % 5) < 2);
      tick();
      check_eq("burst_level_max", {31'd0, level <= 3'd4}, 32'd1);
    end
    drain("burst");
    check_eq("burst_in_eq_out", pop_cnt, push_cnt);
    check_eq("burst_level0",    {29'd0, level}, 32'd0);

    // Flush with a push attempt in the same cycle
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_eq("pre_flush_level", {29'd0, level},    32'd3);
    check_eq("pre_flush_head",  {16'd0, out_data}, 32'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flush_level",    {29'd0, level},     32'd0);
    check_eq("flush_valid",    {31'd0, out_valid}, 32'd0);
    check_eq("flush_in_ready", {31'd0, in_ready},  32'd1);
    check_eq("flush_afull",    {31'd0, afull},     32'd0);
    check_eq("flush_no_push",  push_cnt,           32'd10);
    exp_out = next_in;
    tick();
    in_valid = 1'b0;
    check_eq("post_flush_head",  {16'd0, out_data}, 32'd10);
    check_eq("post_flush_level", {29'd0, level},    32'd1);
    drain("flush");

    // Reset mid-operation, then restart from 0
    in_valid = 1'b1; out_ready = 1'b0;
    tick(); tick();
    check_eq("pre_rst_level", {29'd0, level}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    restart_counts();
    check_eq("mrst_in_ready",  {31'd0, in_ready},  32'd1);
    check_eq("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mrst_level",     {29'd0, level},     32'd0);
    check_eq("mrst_afull",     {31'd0, afull},     32'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    drain("mrst");
    check_eq("mrst_pushes", push_cnt, 32'd5);
    check_eq("mrst_pops",   pop_cnt,  32'd5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
